wm_embed_lane_seq: RTL and testbench

- Sequencer that feeds the team's N-bit mux-based ripple adder and consumes its result.
- Accepts 32-bit words of four packed 8-bit image pixels plus four watermark bits.
- Steps the pixels one at a time through the shared external adder, applying +DELTA or -DELTA per pixel, and saturates each result to 0..255.
- Emits the repacked watermarked word over a valid/ready handshake.

---
 rtl/wm_embed_lane_seq.sv | 139 +++++++++++++
 tb/tb_wm_embed_lane_seq.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wm_embed_lane_seq.sv
// wm_embed_lane_seq: steps four packed 8-bit pixels through a shared external
// N-bit adder, applying +DELTA or -DELTA per lane from the watermark bits,
// saturates each lane result to 0..255 and hands out the repacked word over
// valid/ready.
// Optional: define WM_EMBED_SAT_CNT_EN to implement the saturated-lane
// counter; when undefined, sat_cnt is tied to 0.
module wm_embed_lane_seq #(
  parameter int          N     = 32,
  parameter int unsigned DELTA = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_pix,
  input  logic [3:0]   in_wm,
  output logic [N-1:0] adder_a,
  output logic [N-1:0] adder_b,
  output logic         adder_cin,
  input  logic [N-1:0] adder_sum,
  input  logic         adder_cout,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  out_pix,
  output logic [15:0]  sat_cnt
);

  localparam logic [7:0]   DELTA_B   = DELTA[7:0];
  localparam logic [N-1:0] DELTA_EXT = {{(N-8){1'b0}}, DELTA_B};

  typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;

  state_t       state, state_nxt;
  logic [1:0]   lane;
  logic [31:0]  pix_p0;
  logic [3:0]   wm_p0;
  logic [31:0]  res_p1;
  logic [7:0]   lane_pix;
  logic [8:0]   sat_p0;
  logic [7:0]   lane_res;
  logic         lane_sat;

  // Clamp a signed adder sum to 0..255; bit 8 of the result flags saturation.
  function automatic logic [8:0] sat_lane(input logic signed [N-1:0] s);
    if (s < 0)
      return 9'h100;
    else if (|s[N-2:8])
      return 9'h1FF;
    else
      return {1'b0, s[7:0]};
  endfunction

  // Select the current lane's pixel and saturate the adder's combinational sum.
  always_comb begin
    lane_pix = pix_p0[{lane, 3'b000} +: 8];
    sat_p0   = sat_lane($signed(adder_sum));
    lane_res = sat_p0[7:0];
    lane_sat = sat_p0[8];
  end

  // Drive the shared adder only while stepping lanes; subtract uses ~B + 1.
  always_comb begin
    adder_a   = '0;
    adder_b   = '0;
    adder_cin = 1'b0;
    if (state == CALC) begin
      adder_a = {{(N-8){1'b0}}, lane_pix};
      if (wm_p0[lane]) begin
        adder_b = DELTA_EXT;
      end else begin
        adder_b   = ~DELTA_EXT;
        adder_cin = 1'b1;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)      state_nxt = CALC;
      CALC:    if (lane == 2'd3)  state_nxt = HOLD;
      HOLD:    if (out_ready)     state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  // Control state, lane counter and the result word presented on out_pix.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      lane   <= 2'd0;
      res_p1 <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && in_valid) begin
        lane   <= 2'd0;
        res_p1 <= '0;
      end else if (state == CALC) begin
        res_p1[{lane, 3'b000} +: 8] <= lane_res;
        lane                        <= lane + 2'd1;
      end
    end
  end

  // Input capture register: data only, loaded on accept.
  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid) begin
      pix_p0 <= in_pix;
      wm_p0  <= in_wm;
    end
  end

  assign in_ready  = rst_n & (state == IDLE);
  assign out_valid = (state == HOLD);
  assign out_pix   = res_p1;

`ifdef WM_EMBED_SAT_CNT_EN
  logic [15:0] sat_cnt_q;

  // Count saturated lanes, sticking at the ceiling instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      sat_cnt_q <= 16'd0;
    else if (state == CALC && lane_sat && sat_cnt_q != 16'hFFFF)
      sat_cnt_q <= sat_cnt_q + 16'd1;
  end

  assign sat_cnt = sat_cnt_q;
`else
  logic unused_sat;
  assign unused_sat = lane_sat;
  assign sat_cnt    = 16'd0;
`endif

  logic unused_cout;
  assign unused_cout = adder_cout;

endmodule

// File: tb/tb_wm_embed_lane_seq.sv
// Self-checking bench for wm_embed_lane_seq with a behavioural ripple-adder
// model and an integer-arithmetic reference for the per-lane embedding.
module tb_wm_embed_lane_seq;
  localparam int N     = 32;
  localparam int DELTA = 4;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_pix;
  logic [3:0]   in_wm;
  logic [N-1:0] adder_a;
  logic [N-1:0] adder_b;
  logic         adder_cin;
  logic [N-1:0] adder_sum;
  logic         adder_cout;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_pix;
  logic [15:0]  sat_cnt;

  int checks;
  int errors;
  int exp_sat;

  wm_embed_lane_seq #(.N(N), .DELTA(DELTA)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_pix(in_pix), .in_wm(in_wm),
    .adder_a(adder_a), .adder_b(adder_b), .adder_cin(adder_cin),
    .adder_sum(adder_sum), .adder_cout(adder_cout),
    .out_valid(out_valid), .out_ready(out_ready), .out_pix(out_pix),
    .sat_cnt(sat_cnt)
  );

  // External adder
  assign {adder_cout, adder_sum} = {1'b0, adder_a} + {1'b0, adder_b} + {{N{1'b0}}, adder_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: per-lane pixel +/- DELTA in plain integers, clamped to 0..255.
  function automatic void ref_word(input logic [31:0] p, input logic [3:0] w,
                                   output logic [31:0] o, output int nsat);
    int v;
    o = '0;
    nsat = 0;
    for (int i = 0; i < 4; i++) begin
      v = int'(p[8*i +: 8]) + (w[i] ? DELTA : -DELTA);
      if (v < 0) begin v = 0; nsat++; end
      else if (v > 255) begin v = 255; nsat++; end
      o[8*i +: 8] = v[7:0];
    end
  endfunction

  function automatic int bump_sat(input int cur, input int n);
`ifdef WM_EMBED_SAT_CNT_EN
    return (cur + n > 65535) ? 65535 : cur + n;
`else
    return (n < 0) ? cur : 0;
`endif
  endfunction

  // Transaction driver: offer one word, wait for out_valid, then accept it.
  task automatic run_word(input logic [31:0] p, input logic [3:0] w,
                          output logic [31:0] o, output int lat, output bit ok);
    int n;
    ok = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!in_ready) ok = 1'b0;
    in_valid = 1'b1; in_pix = p; in_wm = w;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    if (!out_valid) ok = 1'b0;
    o = out_pix;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({in_ready, out_valid, adder_cin} !== 3'b000) begin
      errors++; $display("FAIL reset_ctrl: got ready/valid/cin=%b expected 000", {in_ready, out_valid, adder_cin});
    end
    checks++;
    if (out_pix !== 32'h0 || sat_cnt !== 16'h0) begin
      errors++; $display("FAIL reset_data: got out_pix=%h sat_cnt=%h expected 0/0", out_pix, sat_cnt);
    end
    checks++;
    if (adder_a !== '0 || adder_b !== '0) begin
      errors++; $display("FAIL reset_adder: got a=%h b=%h expected 0/0", adder_a, adder_b);
    end
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release_ready: got %b expected 1", in_ready);
    end
    exp_sat = 0;
  endtask

  task automatic test_mixed();
    logic [31:0] o, e; int lat, ns; bit ok;
    ref_word(32'h02FE8010, 4'b0101, e, ns);
    run_word(32'h02FE8010, 4'b0101, o, lat, ok);
    exp_sat = bump_sat(exp_sat, ns);
    checks++;
    if (!ok || lat !== 4) begin
      errors++; $display("FAIL mixed_latency: got ok=%0d lat=%0d expected ok=1 lat=4", ok, lat);
    end
    checks++;
    if (o !== 32'h00FF7C14 || e !== 32'h00FF7C14 || ns != 2) begin
      errors++; $display("FAIL mixed_pix: got %h (model %h, nsat %0d) expected 00ff7c14", o, e, ns);
    end
    checks++;
    if (sat_cnt !== 16'(exp_sat)) begin
      errors++; $display("FAIL mixed_satcnt: got %0d expected %0d", sat_cnt, exp_sat);
    end
  endtask

  task automatic test_boundary();
    logic [31:0] o; int lat; bit ok;
    run_word(32'hFB040004, 4'b1010, o, lat, ok);
    checks++;
    if (!ok || o !== 32'hFF000400) begin
      errors++; $display("FAIL boundary_pix: got %h ok=%0d expected ff000400", o, ok);
    end
    checks++;
    if (sat_cnt !== 16'(exp_sat)) begin
      errors++; $display("FAIL boundary_satcnt: got %0d expected %0d", sat_cnt, exp_sat);
    end
  endtask

  task automatic test_adder_drive();
    logic [31:0] p; logic [3:0] w; logic [N-1:0] ea, eb; int ns; logic [31:0] e;
    p = $urandom; w = 4'($urandom_range(0, 15));
    ref_word(p, w, e, ns);
    in_valid = 1'b1; in_pix = p; in_wm = w;
    @(posedge clk); #1;
    in_valid = 1'b0; in_pix = ~p; in_wm = ~w;
    for (int i = 0; i < 4; i++) begin
      ea = N'(p[8*i +: 8]);
      eb = w[i] ? N'(DELTA) : ~N'(DELTA);
      checks++;
      if (adder_a !== ea || adder_b !== eb || adder_cin !== !w[i]) begin
        errors++; $display("FAIL adder_lane%0d: got a=%h b=%h cin=%b expected a=%h b=%h cin=%b",
                           i, adder_a, adder_b, adder_cin, ea, eb, !w[i]);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (!out_valid || out_pix !== e || adder_a !== '0 || adder_b !== '0 || adder_cin !== 1'b0) begin
      errors++; $display("FAIL adder_hold: got valid=%b pix=%h a=%h b=%h cin=%b expected 1 %h 0 0 0",
                         out_valid, out_pix, adder_a, adder_b, adder_cin, e);
    end
    exp_sat = bump_sat(exp_sat, ns);
    out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] p, o, e; logic [3:0] w; int lat, ns; bit ok;
    for (int k = 0; k < 20; k++) begin
      p = $urandom; w = 4'($urandom_range(0, 15));
      if (k % 5 == 0) p[7:0] = 8'hFF;
      if (k % 7 == 0) p[15:8] = 8'h01;
      ref_word(p, w, e, ns);
      run_word(p, w, o, lat, ok);
      exp_sat = bump_sat(exp_sat, ns);
      checks++;
      if (!ok || o !== e || sat_cnt !== 16'(exp_sat)) begin
        errors++; $display("FAIL random_%0d: got pix=%h sat=%0d ok=%0d expected pix=%h sat=%0d",
                           k, o, sat_cnt, ok, e, exp_sat);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] p, e; logic [3:0] w; int ns, n;
    p = $urandom; w = 4'($urandom_range(0, 15));
    ref_word(p, w, e, ns);
    in_valid = 1'b1; in_pix = p; in_wm = w;
    @(posedge clk); #1;
    n = 0;
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    exp_sat = bump_sat(exp_sat, ns);
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (out_valid !== 1'b1 || out_pix !== e || in_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold_%0d: got valid=%b pix=%h ready=%b expected 1 %h 0",
                           c, out_valid, out_pix, in_ready, e);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release: got valid=%b ready=%b expected 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] p, o, e; logic [3:0] w; int lat, ns; bit ok;
    in_valid = 1'b1; in_pix = 32'hFFFF0000; in_wm = 4'b0011;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_pix !== 32'h0 || sat_cnt !== 16'h0) begin
      errors++; $display("FAIL midreset_outs: got ready=%b valid=%b pix=%h sat=%0d expected 0 0 0 0",
                         in_ready, out_valid, out_pix, sat_cnt);
    end
    checks++;
    if (adder_a !== '0 || adder_b !== '0 || adder_cin !== 1'b0) begin
      errors++; $display("FAIL midreset_adder: got a=%h b=%h cin=%b expected 0 0 0", adder_a, adder_b, adder_cin);
    end
    exp_sat = 0;
    #14 rst_n = 1'b1;
    @(posedge clk); #1;
    p = $urandom; w = 4'($urandom_range(0, 15));
    ref_word(p, w, e, ns);
    run_word(p, w, o, lat, ok);
    exp_sat = bump_sat(exp_sat, ns);
    checks++;
    if (!ok || lat !== 4 || o !== e || sat_cnt !== 16'(exp_sat)) begin
      errors++; $display("FAIL midreset_after: got pix=%h lat=%0d sat=%0d expected pix=%h lat=4 sat=%0d",
                         o, lat, sat_cnt, e, exp_sat);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] words[8], exp_q[$], e; logic [3:0] wms[8];
    int acc_cyc[$], sent, rcvd, cyc, ns; bit acc, xfer; logic [31:0] seen;
    for (int i = 0; i < 8; i++) begin words[i] = $urandom; wms[i] = 4'($urandom_range(0, 15)); end
    sent = 0; rcvd = 0; cyc = 0;
    in_valid = 1'b1; in_pix = words[0]; in_wm = wms[0]; out_ready = 1'b1;
    while (rcvd < 8 && cyc < 120) begin
      acc = in_ready & in_valid;
      xfer = out_valid & out_ready;
      seen = out_pix;
      @(posedge clk); #1; cyc++;
      if (acc) begin
        ref_word(words[sent], wms[sent], e, ns);
        exp_q.push_back(e);
        exp_sat = bump_sat(exp_sat, ns);
        acc_cyc.push_back(cyc);
        sent++;
        if (sent < 8) begin in_pix = words[sent]; in_wm = wms[sent]; end
        else in_valid = 1'b0;
      end
      if (xfer) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL b2b_extra_out: got pix=%h expected none", seen);
        end else begin
          e = exp_q.pop_front();
          if (seen !== e) begin
            errors++; $display("FAIL b2b_word_%0d: got %h expected %h", rcvd, seen, e);
          end
        end
        rcvd++;
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    checks++;
    if (sent != 8 || rcvd != 8) begin
      errors++; $display("FAIL b2b_count: got sent=%0d rcvd=%0d expected 8 8", sent, rcvd);
    end
    for (int i = 1; i < acc_cyc.size(); i++) begin
      checks++;
      if (acc_cyc[i] - acc_cyc[i-1] != 6) begin
        errors++; $display("FAIL b2b_spacing_%0d: got %0d cycles expected 6", i, acc_cyc[i] - acc_cyc[i-1]);
      end
    end
    checks++;
    if (sat_cnt !== 16'(exp_sat)) begin
      errors++; $display("FAIL b2b_satcnt: got %0d expected %0d", sat_cnt, exp_sat);
    end
  endtask

  task automatic test_ceiling();
    logic [31:0] o; int lat, nw; bit ok; int bad;
`ifdef WM_EMBED_SAT_CNT_EN
    force dut.sat_cnt_q = 16'hFFF8;
    #1;
    release dut.sat_cnt_q;
    exp_sat = 16'hFFF8;
    nw = 4;
`else
    nw = 300;
`endif
    bad = 0;
    for (int k = 0; k < nw; k++) begin
      run_word(32'hFFFFFFFF, 4'b1111, o, lat, ok);
      exp_sat = bump_sat(exp_sat, 4);
      checks++;
      if (!ok || o !== 32'hFFFFFFFF || sat_cnt !== 16'(exp_sat)) begin
        errors++; bad++;
        if (bad < 5) $display("FAIL ceiling_%0d: got pix=%h sat=%0d expected ffffffff sat=%0d",
                              k, o, sat_cnt, exp_sat);
      end
    end
  endtask

  initial begin
    checks = 0; errors = 0; exp_sat = 0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_pix = '0; in_wm = '0;
    test_reset();
    test_mixed();
    test_boundary();
    test_adder_drive();
    test_random();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_ceiling();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
